// File: rtl/cv32e40x_bch_redirect_ctrl.sv
// Early fetch redirect for statically predicted branches, with correction on EX mispredict.
// Also keeps saturating prediction/mispredict counters for performance monitoring.
module cv32e40x_bch_redirect_ctrl #(
  parameter int unsigned PRED_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             id_fire_i,
  input  logic             id_bch_i,
  input  logic             id_compressed_i,
  input  logic [31:0]      pc_id_i,
  input  logic [31:0]      bch_target_i,
  input  logic             bch_prediction_i,
  input  logic             ex_resolve_i,
  input  logic             ex_taken_i,
  input  logic             redirect_ready_i,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             mispredict_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pred_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRED     = 3'd1,
    INFLIGHT = 3'd2,
    PRED_OK  = 3'd3,
    CORRECT  = 3'd4
  } state_e;

  localparam logic PRED_EN_L = (PRED_EN != 0);

  state_e           state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      fall_q, fall_d;
  logic             pred_q, pred_d;
  logic             valid_q, valid_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             misp_q, misp_d;
  logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
  logic             cap_pred_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign cap_pred_s = bch_prediction_i & PRED_EN_L;

  // Next-state, capture and redirect request computation
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    fall_d     = fall_q;
    pred_d     = pred_q;
    valid_d    = valid_q;
    rpc_d      = rpc_q;
    misp_d     = 1'b0;
    pred_cnt_d = pred_cnt_q;
    misp_cnt_d = misp_cnt_q;

    if (kill_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (id_fire_i && id_bch_i) begin
            target_d = bch_target_i;
            fall_d   = pc_id_i + (id_compressed_i ? 32'd2 : 32'd4);
            pred_d   = cap_pred_s;
            if (cap_pred_s) begin
              state_d    = PRED;
              valid_d    = 1'b1;
              rpc_d      = bch_target_i;
              pred_cnt_d = sat_inc(pred_cnt_q);
            end else begin
              state_d = INFLIGHT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRED: begin
          if (ex_resolve_i) begin
            if (ex_taken_i == pred_q) begin
              if (redirect_ready_i) begin
                state_d = IDLE;
                valid_d = 1'b0;
              end else begin
                state_d = PRED_OK;
              end
            end else begin
              // Pending target request is replaced in place by the fall-through
              state_d    = CORRECT;
              valid_d    = 1'b1;
              rpc_d      = fall_q;
              misp_d     = 1'b1;
              misp_cnt_d = sat_inc(misp_cnt_q);
            end
          end else if (redirect_ready_i) begin
            state_d = INFLIGHT;
            valid_d = 1'b0;
          end else begin
            state_d = PRED;
          end
        end
        INFLIGHT: begin
          if (ex_resolve_i && (ex_taken_i != pred_q)) begin
            state_d    = CORRECT;
            valid_d    = 1'b1;
            rpc_d      = ex_taken_i ? target_q : fall_q;
            misp_d     = 1'b1;
            misp_cnt_d = sat_inc(misp_cnt_q);
          end else if (ex_resolve_i) begin
            state_d = IDLE;
          end else begin
            state_d = INFLIGHT;
          end
        end
        PRED_OK, CORRECT: begin
          if (redirect_ready_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= 32'd0;
      fall_q     <= 32'd0;
      pred_q     <= 1'b0;
      valid_q    <= 1'b0;
      rpc_q      <= 32'd0;
      misp_q     <= 1'b0;
      pred_cnt_q <= {CNT_W{1'b0}};
      misp_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      fall_q     <= fall_d;
      pred_q     <= pred_d;
      valid_q    <= valid_d;
      rpc_q      <= rpc_d;
      misp_q     <= misp_d;
      pred_cnt_q <= pred_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign redirect_valid_o = valid_q;
  assign redirect_pc_o    = rpc_q;
  assign mispredict_o     = misp_q;
  assign busy_o           = (state_q != IDLE);
  assign pred_cnt_o       = pred_cnt_q;
  assign mispred_cnt_o    = misp_cnt_q;

  cv32e40x_bch_redirect_ctrl_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill_i    (kill_i),
    .id_fire_i (id_fire_i),
    .id_bch_i  (id_bch_i),
    .busy_i    (busy_o)
  );

endmodule

// Protocol checks: ID must not hand over another branch while one is tracked.
module cv32e40x_bch_redirect_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic kill_i,
  input logic id_fire_i,
  input logic id_bch_i,
  input logic busy_i
);

  a_no_fire_when_busy : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(id_fire_i && id_bch_i && busy_i && !kill_i)
  );

endmodule

// File: tb/tb_cv32e40x_bch_redirect_ctrl.sv
// Scenario bench for the branch redirect controller; transferred redirects are scoreboarded.
module tb_cv32e40x_bch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kill, fire, bch, comp, pred, res, taken, rdy;
  logic [31:0] pc, tgt;
  logic        v, misp, busy;
  logic [31:0] rpc;
  logic [15:0] pcnt, mcnt;

  logic        kill2, fire2, bch2, comp2, pred2, res2, taken2, rdy2;
  logic [31:0] pc2, tgt2;
  logic        v2, misp2, busy2;
  logic [31:0] rpc2;
  logic [15:0] pcnt2, mcnt2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cv32e40x_bch_redirect_ctrl #(.PRED_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .kill_i(kill), .id_fire_i(fire), .id_bch_i(bch),
    .id_compressed_i(comp), .pc_id_i(pc), .bch_target_i(tgt), .bch_prediction_i(pred),
    .ex_resolve_i(res), .ex_taken_i(taken), .redirect_ready_i(rdy),
    .redirect_valid_o(v), .redirect_pc_o(rpc), .mispredict_o(misp), .busy_o(busy),
    .pred_cnt_o(pcnt), .mispred_cnt_o(mcnt)
  );

  cv32e40x_bch_redirect_ctrl #(.PRED_EN(0), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .kill_i(kill2), .id_fire_i(fire2), .id_bch_i(bch2),
    .id_compressed_i(comp2), .pc_id_i(pc2), .bch_target_i(tgt2), .bch_prediction_i(pred2),
    .ex_resolve_i(res2), .ex_taken_i(taken2), .redirect_ready_i(rdy2),
    .redirect_valid_o(v2), .redirect_pc_o(rpc2), .mispredict_o(misp2), .busy_o(busy2),
    .pred_cnt_o(pcnt2), .mispred_cnt_o(mcnt2)
  );

  // Scoreboard: every completed redirect handshake must match the next expected PC
  always @(negedge clk) begin
    if (rst_n && v && rdy) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected act_pc=%08h exp=none", rpc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rpc !== e) begin
          n_fail++;
          $display("FAIL sb_pc act=%08h exp=%08h", rpc, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_bch(input logic [31:0] p, input logic [31:0] t, input logic pr, input logic c);
    fire = 1'b1; bch = 1'b1; pc = p; tgt = t; pred = pr; comp = c;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%08h exp=%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {kill, fire, bch, comp, pred, res, taken, rdy} = 8'h00;
    {kill2, fire2, bch2, comp2, pred2, res2, taken2, rdy2} = 8'h00;
    pc = 32'd0; tgt = 32'd0; pc2 = 32'd0; tgt2 = 32'd0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({v, misp, busy, rpc, pcnt, mcnt} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_outputs act=%0h exp=0", {v, misp, busy, rpc, pcnt, mcnt});
    end
  endtask

  task automatic test_backward();
    fire_bch(32'h100, 32'hF0, 1'b1, 1'b0);
    exp_q.push_back(32'hF0);
    cyc();
    fire = 1'b0; bch = 1'b0;
    chk("t1_valid", {31'd0, v}, 32'd1);
    chk("t1_pc", rpc, 32'hF0);
    chk("t1_pcnt", {16'd0, pcnt}, 32'd1);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    chk("t1_inflight", {30'd0, v, busy}, 32'b01);
    res = 1'b1; taken = 1'b1;
    cyc();
    res = 1'b0;
    chk("t1_done", {30'd0, busy, misp}, 32'd0);
  endtask

  task automatic test_forward();
    fire_bch(32'h200, 32'h240, 1'b0, 1'b0);
    cyc();
    fire = 1'b0; bch = 1'b0;
    chk("t2_novalid", {30'd0, v, busy}, 32'b01);
    res = 1'b1; taken = 1'b1;
    exp_q.push_back(32'h240);
    cyc();
    res = 1'b0;
    chk("t2_misp", {30'd0, misp, v}, 32'b11);
    chk("t2_pc", rpc, 32'h240);
    chk("t2_mcnt", {16'd0, mcnt}, 32'd1);
    cyc();
    chk("t2_hold", {30'd0, misp, v}, 32'b01);
    chk("t2_hold_pc", rpc, 32'h240);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    chk("t2_idle", {30'd0, v, busy}, 32'd0);
  endtask

  task automatic test_pred_replace();
    fire_bch(32'h300, 32'h2F0, 1'b1, 1'b1);
    cyc();
    fire = 1'b0; bch = 1'b0;
    chk("t3_pc_pred", rpc, 32'h2F0);
    res = 1'b1; taken = 1'b0;
    exp_q.push_back(32'h302);
    cyc();
    res = 1'b0;
    chk("t3_replace", {30'd0, misp, v}, 32'b11);
    chk("t3_pc_ft", rpc, 32'h302);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    chk("t3_idle", {30'd0, v, busy}, 32'd0);
    chk("t3_cnts", {pcnt, mcnt}, {16'd2, 16'd2});
  endtask

  task automatic test_wrap();
    fire_bch(32'hFFFFFFFC, 32'h1000, 1'b1, 1'b0);
    exp_q.push_back(32'h1000);
    cyc();
    fire = 1'b0; bch = 1'b0;
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    res = 1'b1; taken = 1'b0;
    exp_q.push_back(32'h0);
    cyc();
    res = 1'b0;
    chk("t4_misp", {30'd0, misp, v}, 32'b11);
    chk("t4_pc_wrap", rpc, 32'h0);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
  endtask

  task automatic test_kill();
    fire_bch(32'h400, 32'h480, 1'b0, 1'b0);
    cyc();
    fire = 1'b0; bch = 1'b0;
    res = 1'b1; taken = 1'b1;
    cyc();
    res = 1'b0;
    chk("t5_correct", {31'd0, v}, 32'd1);
    kill = 1'b1;
    cyc();
    kill = 1'b0;
    chk("t5_killed", {29'd0, v, busy, misp}, 32'd0);
    chk("t5_cnts", {pcnt, mcnt}, {16'd3, 16'd4});
    fire_bch(32'h500, 32'h4C0, 1'b1, 1'b0);
    exp_q.push_back(32'h4C0);
    cyc();
    fire = 1'b0; bch = 1'b0;
    chk("t5_refire", {30'd0, v, busy}, 32'b11);
    chk("t5_refire_pc", rpc, 32'h4C0);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    res = 1'b1; taken = 1'b1;
    cyc();
    res = 1'b0;
    kill = 1'b1;
    fire_bch(32'h540, 32'h500, 1'b1, 1'b0);
    cyc();
    kill = 1'b0; fire = 1'b0; bch = 1'b0;
    chk("t5_kill_capture", {14'd0, v, busy, pcnt}, {16'd0, 16'd4});
  endtask

  task automatic test_saturate();
    force dut.misp_cnt_q = 16'hFFFF;
    cyc();
    release dut.misp_cnt_q;
    chk("t6_preload", {16'd0, mcnt}, 32'hFFFF);
    fire_bch(32'h600, 32'h640, 1'b0, 1'b0);
    cyc();
    fire = 1'b0; bch = 1'b0;
    res = 1'b1; taken = 1'b1;
    exp_q.push_back(32'h640);
    cyc();
    res = 1'b0;
    chk("t6_misp", {31'd0, misp}, 32'd1);
    chk("t6_sat", {16'd0, mcnt}, 32'hFFFF);
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    fire2 = 1'b1; bch2 = 1'b1; pc2 = 32'h700; tgt2 = 32'h6F0; pred2 = 1'b1;
    cyc();
    fire2 = 1'b0; bch2 = 1'b0;
    chk("t6_nopred", {14'd0, v2, busy2, pcnt2}, {16'd1, 16'd0});
    res2 = 1'b1; taken2 = 1'b1;
    cyc();
    res2 = 1'b0;
    chk("t6_nopred_misp", {30'd0, misp2, v2}, 32'b11);
    chk("t6_nopred_pc", rpc2, 32'h6F0);
    rdy2 = 1'b1;
    cyc();
    rdy2 = 1'b0;
    chk("t6_nopred_idle", {31'd0, busy2}, 32'd0);
  endtask

  task automatic test_reset_mid();
    fire_bch(32'h800, 32'h7F0, 1'b1, 1'b0);
    cyc();
    fire = 1'b0; bch = 1'b0;
    chk("rm_pending", {31'd0, v}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_async", {14'd0, v, busy, pcnt}, 32'd0);
    chk("rm_pc", rpc, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_backward();
    test_forward();
    test_pred_replace();
    test_wrap();
    test_kill();
    test_saturate();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover act=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
